// File: rtl/dataplane_regs_pkg.sv
// Shared register map constants for the dataplane AXI4-Lite register file.
// Offsets, response codes, ID default, CTRL bit indices, byte-strobe merge helper.
package dataplane_regs_pkg;

    localparam logic [7:0] REG_ID_OFFS         = 8'h00;
    localparam logic [7:0] REG_SCRATCH_OFFS    = 8'h04;
    localparam logic [7:0] REG_CTRL_OFFS       = 8'h08;
    localparam logic [7:0] REG_STATUS_OFFS     = 8'h0C;
    localparam logic [7:0] REG_RX_CNT_OFFS     = 8'h10;
    localparam logic [7:0] REG_IRQ_STATUS_OFFS = 8'h14;
    localparam logic [7:0] REG_IRQ_EN_OFFS     = 8'h18;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [31:0] ID_DEFAULT  = 32'hD47A_0001;
    localparam logic [31:0] RD_UNMAPPED = 32'hDEAD_BEEF;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_SRST_BIT = 1;

    function automatic logic [31:0] apply_strb(
        input logic [31:0] cur,
        input logic [31:0] wdat,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wdat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dataplane_axil_wr_ctrl.sv
// AXI4-Lite write-channel front end: independent AW/W holding registers and B handshake.
// Ports: aclk/aresetn, en (ready gate), AW/W/B channels, wr_resp in, commit + held addr/data/strb out.
module dataplane_axil_wr_ctrl
    import dataplane_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [1:0]            wr_resp,
    output logic                  commit,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic [3:0]            wr_strb
);

    logic                  aw_full;
    logic                  w_full;
    logic                  done;
    logic [ADDR_WIDTH-1:2] aw_word;
    logic                  unused_lo;

    assign unused_lo = &{1'b0, awaddr[1:0]};

    assign awready = en & ~aw_full;
    assign wready  = en & ~w_full;
    // Response is valid for exactly as long as both halves are held;
    // the register update happens only in the first of those cycles.
    assign bvalid  = aw_full & w_full;
    assign bresp   = bvalid ? wr_resp : RESP_OKAY;
    assign commit  = bvalid & ~done;
    assign wr_addr = {aw_word, 2'b00};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            done    <= 1'b0;
            aw_word <= '0;
            wr_data <= '0;
            wr_strb <= '0;
        end else if (bvalid && bready) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_full <= 1'b1;
                aw_word <= awaddr[ADDR_WIDTH-1:2];
            end
            if (wvalid && wready) begin
                w_full  <= 1'b1;
                wr_data <= wdata;
                wr_strb <= wstrb;
            end
            if (commit) done <= 1'b1;
        end
    end

endmodule

// File: rtl/dataplane_axil_regs.sv
// AXI4-Lite register file for dataplane control/status (ID, scratch, ctrl, status, rx count, irq).
// Ports: aclk/aresetn, s_axil_* slave, dp_enable/dp_soft_rst out, dp_status/rx_pkt_pulse in, irq out.
// Optional: DATAPLANE_AXIL_IRQ_EN enables IRQ_STATUS/IRQ_EN and the irq output.
module dataplane_axil_regs
    import dataplane_regs_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic                  dp_enable,
    output logic                  dp_soft_rst,
    input  logic [31:0]           dp_status,
    input  logic                  rx_pkt_pulse,
    output logic                  irq
);

    localparam logic [ADDR_WIDTH-1:0] A_ID   = ADDR_WIDTH'(REG_ID_OFFS);
    localparam logic [ADDR_WIDTH-1:0] A_SCR  = ADDR_WIDTH'(REG_SCRATCH_OFFS);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(REG_CTRL_OFFS);
    localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'(REG_STATUS_OFFS);
    localparam logic [ADDR_WIDTH-1:0] A_RX   = ADDR_WIDTH'(REG_RX_CNT_OFFS);
    localparam logic [ADDR_WIDTH-1:0] A_IST  = ADDR_WIDTH'(REG_IRQ_STATUS_OFFS);
    localparam logic [ADDR_WIDTH-1:0] A_IEN  = ADDR_WIDTH'(REG_IRQ_EN_OFFS);

    logic                  rdy_en;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] wa;
    logic [ADDR_WIDTH-1:0] ra;
    logic [31:0]           wd;
    logic [3:0]            ws;
    logic [1:0]            wr_resp;
    logic [31:0]           scratch;
    logic                  ctrl_en;
    logic [31:0]           rx_cnt;
    logic [31:0]           rd_data;
    logic [1:0]            rd_resp;
    logic                  unused_lo;
`ifdef DATAPLANE_AXIL_IRQ_EN
    logic                  irq_st;
    logic                  irq_en_q;
    logic                  irq_q;
`endif

    function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] a);
        logic hit;
        hit = (a == A_ID) || (a == A_SCR) || (a == A_CTRL) ||
              (a == A_STAT) || (a == A_RX);
`ifdef DATAPLANE_AXIL_IRQ_EN
        hit = hit || (a == A_IST) || (a == A_IEN);
`endif
        return hit;
    endfunction

    assign unused_lo = &{1'b0, s_axil_araddr[1:0]};
    assign ra        = {s_axil_araddr[ADDR_WIDTH-1:2], 2'b00};
    assign wr_resp   = is_mapped(wa) ? RESP_OKAY : RESP_SLVERR;

    // Holds readies low through the reset cycle itself.
    always_ff @(posedge aclk) begin
        if (!aresetn) rdy_en <= 1'b0;
        else          rdy_en <= 1'b1;
    end

    dataplane_axil_wr_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_ctrl (
        .aclk    (aclk),
        .aresetn (aresetn),
        .en      (rdy_en),
        .awaddr  (s_axil_awaddr),
        .awvalid (s_axil_awvalid),
        .awready (s_axil_awready),
        .wdata   (s_axil_wdata),
        .wstrb   (s_axil_wstrb),
        .wvalid  (s_axil_wvalid),
        .wready  (s_axil_wready),
        .bresp   (s_axil_bresp),
        .bvalid  (s_axil_bvalid),
        .bready  (s_axil_bready),
        .wr_resp (wr_resp),
        .commit  (commit),
        .wr_addr (wa),
        .wr_data (wd),
        .wr_strb (ws)
    );

    logic hit_scr, hit_ctrl, hit_rx;
    assign hit_scr  = commit & (wa == A_SCR);
    assign hit_ctrl = commit & (wa == A_CTRL);
    assign hit_rx   = commit & (wa == A_RX);

    assign dp_enable   = ctrl_en;
    assign dp_soft_rst = hit_ctrl & ws[0] & wd[CTRL_SRST_BIT];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            scratch <= '0;
            ctrl_en <= 1'b0;
            rx_cnt  <= '0;
        end else begin
            if (hit_scr) scratch <= apply_strb(scratch, wd, ws);
            if (hit_ctrl && ws[0]) ctrl_en <= wd[CTRL_EN_BIT];
            // Clearing write takes priority over a coincident packet.
            if (hit_rx)            rx_cnt <= '0;
            else if (rx_pkt_pulse) rx_cnt <= rx_cnt + 32'd1;
        end
    end

`ifdef DATAPLANE_AXIL_IRQ_EN
    logic w1c;
    assign w1c = commit & (wa == A_IST) & ws[0] & wd[0];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            irq_st   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_st <= (irq_st & ~w1c) | rx_pkt_pulse;
            if (commit && (wa == A_IEN) && ws[0]) irq_en_q <= wd[0];
            irq_q <= irq_st & irq_en_q;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = RD_UNMAPPED;
        rd_resp = RESP_SLVERR;
        unique case (1'b1)
            (ra == A_ID):   begin rd_data = ID_VALUE;           rd_resp = RESP_OKAY; end
            (ra == A_SCR):  begin rd_data = scratch;            rd_resp = RESP_OKAY; end
            (ra == A_CTRL): begin rd_data = {31'd0, ctrl_en};   rd_resp = RESP_OKAY; end
            (ra == A_STAT): begin rd_data = dp_status;          rd_resp = RESP_OKAY; end
            (ra == A_RX):   begin rd_data = rx_cnt;             rd_resp = RESP_OKAY; end
`ifdef DATAPLANE_AXIL_IRQ_EN
            (ra == A_IST):  begin rd_data = {31'd0, irq_st};    rd_resp = RESP_OKAY; end
            (ra == A_IEN):  begin rd_data = {31'd0, irq_en_q};  rd_resp = RESP_OKAY; end
`endif
            default: ;
        endcase
    end

    assign s_axil_arready = rdy_en & ~s_axil_rvalid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= '0;
        end else if (s_axil_arvalid && s_axil_arready) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_data;
            s_axil_rresp  <= rd_resp;
        end else if (s_axil_rvalid && s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dataplane_axil_regs.sv
// Self-checking bench for dataplane_axil_regs: directed cases plus randomized traffic vs a register model.
// Honours DATAPLANE_AXIL_IRQ_EN for the interrupt registers.
module tb_dataplane_axil_regs;
    import dataplane_regs_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        dp_enable;
    logic        dp_soft_rst;
    logic [31:0] dp_status = '0;
    logic        rx_pkt_pulse = 1'b0;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_scratch;
    logic        m_en;
    logic [31:0] m_rx;
    logic        m_ist;
    logic        m_ie;

`ifdef DATAPLANE_AXIL_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    always #5 aclk = ~aclk;

    dataplane_axil_regs dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .dp_enable      (dp_enable),
        .dp_soft_rst    (dp_soft_rst),
        .dp_status      (dp_status),
        .rx_pkt_pulse   (rx_pkt_pulse),
        .irq            (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_scratch = 0; m_en = 0; m_rx = 0; m_ist = 0; m_ie = 0;
    endfunction

    function automatic void model_read(input logic [7:0] a,
                                       output logic [31:0] d, output logic [1:0] r);
        r = 2'b00;
        d = 32'hDEAD_BEEF;
        case (a)
            8'h00: d = 32'hD47A_0001;
            8'h04: d = m_scratch;
            8'h08: d = {31'd0, m_en};
            8'h0C: d = dp_status;
            8'h10: d = m_rx;
            8'h14: if (IRQ_ON) d = {31'd0, m_ist}; else r = 2'b10;
            8'h18: if (IRQ_ON) d = {31'd0, m_ie};  else r = 2'b10;
            default: r = 2'b10;
        endcase
    endfunction

    function automatic void model_write(input logic [7:0] a, input logic [31:0] d,
                                        input logic [3:0] s, output logic [1:0] r);
        r = 2'b00;
        case (a)
            8'h00, 8'h0C: ;
            8'h04: for (int i = 0; i < 4; i++) if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
            8'h08: if (s[0]) m_en = d[0];
            8'h10: m_rx = 0;
            8'h14: if (IRQ_ON) begin if (s[0] && d[0]) m_ist = 0; end else r = 2'b10;
            8'h18: if (IRQ_ON) begin if (s[0]) m_ie = d[0]; end else r = 2'b10;
            default: r = 2'b10;
        endcase
    endfunction

    // Drives AW and W with independent start delays; pulse_commit drives
    // rx_pkt_pulse in the commit cycle; hold_b leaves bready low.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly,
                             input bit pulse_commit, input bit hold_b,
                             output logic [1:0] resp, output logic srst);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            @(negedge aclk);
            chk("bvalid_early", {31'd0, bvalid}, 32'd0);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) begin
            chk("wr_hs_timeout", 32'd0, 32'd1);
            resp = 2'bxx; srst = 1'b0;
            return;
        end
        rx_pkt_pulse = pulse_commit;
        @(negedge aclk);
        chk("bvalid_lat", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        srst = dp_soft_rst;
        if (!hold_b) bready = 1;
        @(posedge aclk); #1;
        rx_pkt_pulse = 0;
        bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] a, input int rr_dly,
                            output logic [31:0] d, output logic [1:0] r);
        bit hs;
        int cyc;
        hs = 0; cyc = 0;
        araddr = a; arvalid = 1;
        while (!hs && cyc < 40) begin
            @(negedge aclk);
            hs = arready;
            @(posedge aclk); #1;
            cyc++;
        end
        arvalid = 0;
        if (!hs) begin
            chk("rd_hs_timeout", 32'd0, 32'd1);
            d = 'x; r = 'x;
            return;
        end
        @(negedge aclk);
        chk("rvalid_lat", {31'd0, rvalid}, 32'd1);
        d = rdata; r = rresp;
        for (int i = 0; i < rr_dly; i++) begin
            @(posedge aclk); #1;
            @(negedge aclk);
            chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
            chk("rdata_hold", rdata, d);
        end
        rready = 1;
        @(posedge aclk); #1;
        rready = 0;
        chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a);
        logic [31:0] d, ed;
        logic [1:0]  r, er;
        model_read(a, ed, er);
        axi_read(a, 0, d, r);
        chk({tag, "_data"}, d, ed);
        chk({tag, "_resp"}, {30'd0, r}, {30'd0, er});
    endtask

    task automatic wr_do(input string tag, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int aw_dly, input int w_dly,
                         input bit pulse);
        logic [1:0] r, er;
        logic       sr;
        axi_write(a, d, s, aw_dly, w_dly, pulse, 0, r, sr);
        model_write(a, d, s, er);
        if (pulse) begin
            if (a != 8'h10) m_rx = m_rx + 1;
            m_ist = 1;
        end
        chk({tag, "_bresp"}, {30'd0, r}, {30'd0, er});
        chk({tag, "_srst"}, {31'd0, sr}, {31'd0, (a == 8'h08) && s[0] && d[1]});
    endtask

    task automatic pulses(input int k);
        for (int i = 0; i < k; i++) begin
            rx_pkt_pulse = 1;
            @(posedge aclk); #1;
        end
        rx_pkt_pulse = 0;
        m_rx = m_rx + k;
        if (k > 0) m_ist = 1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        sr;
        logic [7:0]  addrs [9];
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40};

        model_reset();
        dp_status = $urandom;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_awready", {31'd0, awready}, 0);
        chk("rst_wready", {31'd0, wready}, 0);
        chk("rst_arready", {31'd0, arready}, 0);
        chk("rst_bvalid", {31'd0, bvalid}, 0);
        chk("rst_rvalid", {31'd0, rvalid}, 0);
        chk("rst_bresp", {30'd0, bresp}, 0);
        chk("rst_rresp", {30'd0, rresp}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_en", {31'd0, dp_enable}, 0);
        chk("rst_srst", {31'd0, dp_soft_rst}, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        aresetn = 1;
        @(posedge aclk); #1;
        chk("post_awready", {31'd0, awready}, 1);
        chk("post_wready", {31'd0, wready}, 1);
        chk("post_arready", {31'd0, arready}, 1);

        wr_do("scr_a", 8'h04, 32'hAAAA_AAAA, 4'hF, 0, 0, 0);
        axi_read(8'h04, 2, d, r);
        chk("scr_a_rd", d, 32'hAAAA_AAAA);
        chk("scr_a_rresp", {30'd0, r}, 0);

        wr_do("scr_f", 8'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        wr_do("wfirst", 8'h04, 32'h1234_5678, 4'b0011, 3, 0, 0);
        axi_read(8'h04, 0, d, r);
        chk("strb_rd", d, 32'hFFFF_5678);
        wr_do("awfirst", 8'h04, 32'h0BAD_F00D, 4'b1100, 0, 2, 0);
        rd_chk("awfirst_rd", 8'h04);

        axi_read(8'h00, 0, d, r);
        chk("id_rd", d, 32'hD47A_0001);
        chk("id_resp", {30'd0, r}, 0);
        axi_read(8'h40, 0, d, r);
        chk("unm_rd", d, 32'hDEAD_BEEF);
        chk("unm_rresp", {30'd0, r}, 2);
        axi_write(8'h40, 32'h1, 4'hF, 0, 0, 0, 0, r, sr);
        chk("unm_bresp", {30'd0, r}, 2);
        wr_do("ro_id", 8'h00, 32'h5555_5555, 4'hF, 1, 0, 0);
        rd_chk("ro_id_rd", 8'h00);

        pulses(5);
        axi_read(8'h10, 0, d, r);
        chk("rx5", d, 32'd5);
        wr_do("rx_clr", 8'h10, 32'h0, 4'hF, 0, 0, 1);
        axi_read(8'h10, 0, d, r);
        chk("rx_clr_win", d, 32'd0);

`ifdef DATAPLANE_AXIL_IRQ_EN
        wr_do("ien", 8'h18, 32'h1, 4'hF, 0, 0, 0);
        @(posedge aclk); #1;
        chk("irq_pend", {31'd0, irq}, 1);
        wr_do("w1c", 8'h14, 32'h1, 4'hF, 0, 0, 0);
        @(posedge aclk); #1;
        chk("irq_w1c", {31'd0, irq}, 0);
        pulses(1);
        chk("irq_reg_lat", {31'd0, irq}, 0);
        @(posedge aclk); #1;
        chk("irq_set", {31'd0, irq}, 1);
        wr_do("w1c_col", 8'h14, 32'h1, 4'hF, 0, 0, 1);
        @(posedge aclk); #1;
        chk("irq_col", {31'd0, irq}, 1);
        rd_chk("ist_col", 8'h14);
`else
        rd_chk("ist_off", 8'h14);
        rd_chk("ien_off", 8'h18);
        wr_do("ien_off_wr", 8'h18, 32'h1, 4'hF, 0, 0, 0);
        pulses(2);
        chk("irq_off", {31'd0, irq}, 0);
`endif

        axi_write(8'h08, 32'h3, 4'hF, 0, 0, 0, 0, r, sr);
        model_write(8'h08, 32'h3, 4'hF, r);
        chk("srst_pulse", {31'd0, sr}, 1);
        chk("srst_once", {31'd0, dp_soft_rst}, 0);
        chk("ctrl_en", {31'd0, dp_enable}, 1);
        axi_read(8'h08, 0, d, r);
        chk("ctrl_rd", d, 32'h1);

        for (int n = 0; n < 200; n++) begin
            int op;
            logic [7:0] a;
            op = $urandom_range(0, 2);
            a = addrs[$urandom_range(0, 8)];
            if (op == 0) begin
                wr_do("rnd_wr", a, $urandom, 4'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
            end else if (op == 1) begin
                dp_status = $urandom;
                rd_chk("rnd_rd", a);
            end else begin
                pulses($urandom_range(1, 4));
            end
            @(posedge aclk); #1;
            chk("rnd_en", {31'd0, dp_enable}, {31'd0, m_en});
            chk("rnd_irq", {31'd0, irq}, {31'd0, IRQ_ON & m_ist & m_ie});
        end

        wr_do("pre_rst", 8'h08, 32'h1, 4'hF, 0, 0, 0);
        axi_write(8'h04, 32'h5555_0000, 4'hF, 0, 0, 0, 1, r, sr);
        aresetn = 0;
        @(posedge aclk); #1;
        model_reset();
        chk("mid_rst_bvalid", {31'd0, bvalid}, 0);
        chk("mid_rst_en", {31'd0, dp_enable}, 0);
        chk("mid_rst_awready", {31'd0, awready}, 0);
        aresetn = 1;
        @(posedge aclk); #1;
        rd_chk("mid_rst_scr", 8'h04);
        rd_chk("mid_rst_rx", 8'h10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
